// File: rtl/sms_cycle_sequencer.sv
`default_nettype none
// sms_cycle_sequencer: arbitrated timing-point sequencer that drives two SMS set/reset trigger pairs.
// Optional build macro SMS_CYCLE_SINGLE_STEP_EN adds a `step` input that advances RUN one point per rising edge.
module sms_cycle_sequencer #(
  parameter int NUM_PTS = 10,
  parameter int SET1_PT = 0,
  parameter int RST1_PT = 5,
  parameter int SET2_PT = 2,
  parameter int RST2_PT = 8
) (
  input  logic       clk,
  input  logic       r,
  input  logic       req0,
  input  logic       req1,
`ifdef SMS_CYCLE_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       done,
  output logic [3:0] tp,
  output logic       set1_n,
  output logic       rst1_n,
  output logic       set2_n,
  output logic       rst2_n,
  output logic       mr_n
);

  generate
    if (NUM_PTS < 4 || NUM_PTS > 16) begin : g_bad_num_pts
      $error("sms_cycle_sequencer: NUM_PTS must be within 4..16");
    end
  endgenerate

  localparam logic [3:0] LAST_PT = 4'(NUM_PTS - 1);
  localparam logic [3:0] S1_PT   = 4'(SET1_PT);
  localparam logic [3:0] R1_PT   = 4'(RST1_PT);
  localparam logic [3:0] S2_PT   = 4'(SET2_PT);
  localparam logic [3:0] R2_PT   = 4'(RST2_PT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_RUN  = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tp_q, tp_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       last0_q, last0_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       set1_n_q, set1_n_d;
  logic       rst1_n_q, rst1_n_d;
  logic       set2_n_q, set2_n_d;
  logic       rst2_n_q, rst2_n_d;
  logic       enter_pt;
  logic       adv;

`ifdef SMS_CYCLE_SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge r) begin
    if (!r) step_q <= 1'b0;
    else    step_q <= step;
  end
  assign adv = step & ~step_q;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    tp_d     = tp_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    last0_d  = last0_q;
    enter_pt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) state_d = S_ARB;
      end
      S_ARB: begin
        // I/O wins when it is the only requester or console had the last cycle.
        if (req1 && (last0_q || !req0)) begin
          gnt1_d   = 1'b1;
          last0_d  = 1'b0;
          tp_d     = 4'd0;
          enter_pt = 1'b1;
          state_d  = S_RUN;
        end else if (req0) begin
          gnt0_d   = 1'b1;
          last0_d  = 1'b1;
          tp_d     = 4'd0;
          enter_pt = 1'b1;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (adv) begin
          if (tp_q == LAST_PT) begin
            tp_d    = 4'd0;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            state_d = S_END;
          end else begin
            tp_d     = tp_q + 4'd1;
            enter_pt = 1'b1;
          end
        end
      end
      S_END: begin
        state_d = (req0 || req1) ? S_ARB : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_END);
    // Reset dominates when a set and reset share the same point.
    set1_n_d = ~(enter_pt && (tp_d == S1_PT) && (S1_PT != R1_PT));
    rst1_n_d = ~(enter_pt && (tp_d == R1_PT));
    set2_n_d = ~(enter_pt && (tp_d == S2_PT) && (S2_PT != R2_PT));
    rst2_n_d = ~(enter_pt && (tp_d == R2_PT));
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q  <= S_IDLE;
      tp_q     <= 4'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      last0_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      set1_n_q <= 1'b1;
      rst1_n_q <= 1'b1;
      set2_n_q <= 1'b1;
      rst2_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      tp_q     <= tp_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      last0_q  <= last0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      set1_n_q <= set1_n_d;
      rst1_n_q <= rst1_n_d;
      set2_n_q <= set2_n_d;
      rst2_n_q <= rst2_n_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign tp     = tp_q;
  assign set1_n = set1_n_q;
  assign rst1_n = rst1_n_q;
  assign set2_n = set2_n_q;
  assign rst2_n = rst2_n_q;
  assign mr_n   = r;

endmodule
`default_nettype wire

// File: tb/tb_sms_cycle_sequencer.sv
`default_nettype none
// tb_sms_cycle_sequencer: directed vector table plus hand-written multi-cycle sequences.
module tb_sms_cycle_sequencer;
  logic clk = 1'b0;
  logic r = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic b_req0 = 1'b0;
  logic b_req1 = 1'b0;
`ifdef SMS_CYCLE_SINGLE_STEP_EN
  logic step = 1'b0;
  logic b_step = 1'b0;
`endif

  wire       gnt0, gnt1, busy, done, set1_n, rst1_n, set2_n, rst2_n, mr_n;
  wire [3:0] tp;
  wire       b_gnt0, b_gnt1, b_busy, b_done, b_set1_n, b_rst1_n, b_set2_n, b_rst2_n, b_mr_n;
  wire [3:0] b_tp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sms_cycle_sequencer u_dut (
    .clk(clk), .r(r), .req0(req0), .req1(req1),
`ifdef SMS_CYCLE_SINGLE_STEP_EN
    .step(step),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .tp(tp),
    .set1_n(set1_n), .rst1_n(rst1_n), .set2_n(set2_n), .rst2_n(rst2_n), .mr_n(mr_n)
  );

  sms_cycle_sequencer #(.NUM_PTS(10), .SET1_PT(3), .RST1_PT(3), .SET2_PT(2), .RST2_PT(8)) u_dut_same (
    .clk(clk), .r(r), .req0(b_req0), .req1(b_req1),
`ifdef SMS_CYCLE_SINGLE_STEP_EN
    .step(b_step),
`endif
    .gnt0(b_gnt0), .gnt1(b_gnt1), .busy(b_busy), .done(b_done), .tp(b_tp),
    .set1_n(b_set1_n), .rst1_n(b_rst1_n), .set2_n(b_set2_n), .rst2_n(b_rst2_n), .mr_n(b_mr_n)
  );

  wire [11:0] obs = {gnt0, gnt1, busy, done, tp, set1_n, rst1_n, set2_n, rst2_n};

  typedef struct {
    logic        rq0;
    logic        rq1;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output vector for the default points A=set1, C=set2, F=rst1, I=rst2.
  function automatic logic [11:0] mdl(input logic g0, input logic g1, input logic bz, input logic dn,
                                      input logic [3:0] t, input logic pulse);
    logic s1, r1, s2, r2;
    s1 = !(pulse && t == 4'd0);
    r1 = !(pulse && t == 4'd5);
    s2 = !(pulse && t == 4'd2);
    r2 = !(pulse && t == 4'd8);
    return {g0, g1, bz, dn, t, s1, r1, s2, r2};
  endfunction

  task automatic run_cycle(input logic who, input int drop_at);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("cycle gnt%0d tp%0d", who, k), {4'd0, obs}, {4'd0, mdl(!who, who, 1'b1, 1'b0, 4'(k), 1'b1)});
      if (k == drop_at) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    tick();
    chk($sformatf("end gnt%0d", who), {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0)});
  endtask

  initial begin
    // fields: gnt0 gnt1 busy done tp set1_n rst1_n set2_n rst2_n
    tbl[0]  = '{1'b1, 1'b0, 12'b0_0_1_0_0000_1_1_1_1};
    tbl[1]  = '{1'b1, 1'b0, 12'b1_0_1_0_0000_0_1_1_1};
    tbl[2]  = '{1'b0, 1'b0, 12'b1_0_1_0_0001_1_1_1_1};
    tbl[3]  = '{1'b0, 1'b0, 12'b1_0_1_0_0010_1_1_0_1};
    tbl[4]  = '{1'b0, 1'b0, 12'b1_0_1_0_0011_1_1_1_1};
    tbl[5]  = '{1'b0, 1'b0, 12'b1_0_1_0_0100_1_1_1_1};
    tbl[6]  = '{1'b0, 1'b0, 12'b1_0_1_0_0101_1_0_1_1};
    tbl[7]  = '{1'b0, 1'b0, 12'b1_0_1_0_0110_1_1_1_1};
    tbl[8]  = '{1'b0, 1'b0, 12'b1_0_1_0_0111_1_1_1_1};
    tbl[9]  = '{1'b0, 1'b0, 12'b1_0_1_0_1000_1_1_1_0};
    tbl[10] = '{1'b0, 1'b0, 12'b1_0_1_0_1001_1_1_1_1};
    tbl[11] = '{1'b0, 1'b0, 12'b0_0_1_1_0000_1_1_1_1};
    tbl[12] = '{1'b0, 1'b0, 12'b0_0_0_0_0000_1_1_1_1};

    #12;
    chk("reset outputs", {4'd0, obs}, {4'd0, 12'b0_0_0_0_0000_1_1_1_1});
    chk("reset mr_n", {15'd0, mr_n}, 16'd0);
    r = 1'b1;
    #1;
    chk("mr_n follows r", {15'd0, mr_n}, 16'd1);

`ifdef SMS_CYCLE_SINGLE_STEP_EN
    req0 = 1'b1;
    tick();
    chk("step arb", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0)});
    tick();
    chk("step tp0", {4'd0, obs}, {4'd0, mdl(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1)});
    req0 = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      for (int w = 0; w < 4; w++) begin
        tick();
        chk($sformatf("step hold tp%0d", e - 1), {4'd0, obs}, {4'd0, mdl(1'b1, 1'b0, 1'b1, 1'b0, 4'(e - 1), 1'b0)});
      end
      step = 1'b1;
      tick();
      chk($sformatf("step edge tp%0d", e), {4'd0, obs}, {4'd0, mdl(1'b1, 1'b0, 1'b1, 1'b0, 4'(e), 1'b1)});
      step = 1'b0;
    end
    tick();
    chk("step after edges", {4'd0, obs}, {4'd0, mdl(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0)});
`else
    // Single console cycle from the vector table.
    for (int i = 0; i < 13; i++) begin
      req0 = tbl[i].rq0;
      req1 = tbl[i].rq1;
      tick();
      chk($sformatf("table row %0d", i), {4'd0, obs}, {4'd0, tbl[i].exp});
    end

    // Request dropped during ARB: back to IDLE with no grant.
    req0 = 1'b1;
    tick();
    chk("drop arb enter", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0)});
    req0 = 1'b0;
    tick();
    chk("drop arb idle", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0)});

    // Both requesters held: grants alternate with two dead clocks between cycles.
    r = 1'b0;
    #2;
    r = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk("fair arb 1", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0)});
    run_cycle(1'b0, -1);
    tick();
    chk("fair arb 2", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0)});
    run_cycle(1'b1, -1);
    tick();
    chk("fair arb 3", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0)});
    run_cycle(1'b0, -1);
    tick();
    chk("fair arb 4", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0)});
    run_cycle(1'b1, 9);
    tick();
    chk("fair idle", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0)});

    // Asynchronous reset at tp=6 of an I/O cycle.
    req1 = 1'b1;
    tick();
    chk("rst arb", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0)});
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk($sformatf("rst run tp%0d", k), {4'd0, obs}, {4'd0, mdl(1'b0, 1'b1, 1'b1, 1'b0, 4'(k), 1'b1)});
    end
    #1;
    r = 1'b0;
    #1;
    chk("async reset outputs", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0)});
    chk("async reset mr_n", {15'd0, mr_n}, 16'd0);
    tick();
    chk("held reset no done", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0)});
    r = 1'b1;
    tick();
    chk("restart arb", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0)});
    // req1 dropped at tp=4: cycle still completes.
    run_cycle(1'b1, 4);
    tick();
    chk("drop mid idle", {4'd0, obs}, {4'd0, mdl(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0)});

    // Coincident set/reset point on trigger 1: reset dominates.
    b_req0 = 1'b1;
    tick();
    tick();
    chk("same pt tp0 set1_n", {15'd0, b_set1_n}, 16'd1);
    chk("same pt tp0 gnt0", {15'd0, b_gnt0}, 16'd1);
    b_req0 = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    chk("same pt tp", {12'd0, b_tp}, 16'd3);
    chk("same pt set1_n", {15'd0, b_set1_n}, 16'd1);
    chk("same pt rst1_n", {15'd0, b_rst1_n}, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
